// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer.
// Contents: APB completer state encoding, CTRL register address and CTRL bit positions.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StRdwait
  } apb_state_t;

  localparam int unsigned CtrlAddr  = 0;
  localparam int unsigned StartBit  = 0;
  localparam int unsigned BusyBit   = 1;
  localparam int unsigned ResultLsb = 2;

endpackage

// File: rtl/regfile_mem.sv
// Simple dual-port synchronous RAM backing the register file.
// Ports:
//   clk, rst                 clock, async active-low reset (read registers only)
//   we_a, addr_a, wdata_a    port A write (APB side)
//   rdata_a                  port A read data, 1-cycle latency
//   addr_b, rdata_b          port B read (core side), 1-cycle latency
// Address 0 (CTRL) and addresses >= Depth read as zero on both ports.
module regfile_mem #(
  parameter int unsigned Width = 24,
  parameter int unsigned AddrW = 13,
  parameter int unsigned Depth = 4097
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_a,
  input  logic [AddrW-1:0] addr_a,
  input  logic [Width-1:0] wdata_a,
  output logic [Width-1:0] rdata_a,
  input  logic [AddrW-1:0] addr_b,
  output logic [Width-1:0] rdata_b
);

  // Entry 0 is never written; it only keeps indexing identical to the bus address.
  logic [Width-1:0] mem [Depth];

  logic valid_a;
  logic valid_b;

  assign valid_a = (addr_a != '0) && (32'(addr_a) < Depth);
  assign valid_b = (addr_b != '0) && (32'(addr_b) < Depth);

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (we_a && valid_a) begin
      mem[addr_a] <= wdata_a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= valid_a ? mem[addr_a] : '0;
      rdata_b <= valid_b ? mem[addr_b] : '0;
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer holding the CTRL/STATUS register (address 0) and a word-addressed
// register file (addresses 1..DEPTH-1) that the recognizer core reads directly.
// Ports:
//   clk, rst                          clock, async active-low reset
//   PSEL PENABLE PWRITE PADDR PWDATA  APB request
//   PRDATA PREADY PSLVERR             APB response
//   start_work                        level to core, high while it computes
//   core_rd_addr, core_rd_data        core read port, 1-cycle latency
//   core_done, core_result            completion pulse and recognizer result
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 24,
  parameter int unsigned AMBA_ADDR_DEPTH = 12,
  parameter int unsigned DEPTH           = 4097
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [AMBA_ADDR_DEPTH:0] PADDR,
  input  logic [AMBA_WORD-1:0]     PWDATA,
  output logic [AMBA_WORD-1:0]     PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic                     start_work,
  input  logic [AMBA_ADDR_DEPTH:0] core_rd_addr,
  output logic [AMBA_WORD-1:0]     core_rd_data,
  input  logic                     core_done,
  input  logic [1:0]               core_result
);

  localparam int unsigned AW = AMBA_ADDR_DEPTH + 1;

  apb_state_t         state_q;
  logic [AW-1:0]      addr_q;
  logic               write_q;
  logic [AMBA_WORD-1:0] wdata_q;
  logic               start_q;
  logic               busy_q;
  logic [1:0]         result_q;
  logic [AMBA_WORD-1:0] prdata_q;

  logic               addr_ctrl;
  logic               addr_oor;
  logic               fast_acc;
  logic               read_acc;
  logic               ctrl_wr;
  logic               mem_we;
  logic [AMBA_WORD-1:0] ctrl_word;
  logic [AMBA_WORD-1:0] mem_rdata_a;

  assign addr_ctrl = (addr_q == AW'(CtrlAddr));
  assign addr_oor  = (32'(addr_q) >= DEPTH);

  // StSetup is entered only for writes and CTRL reads; the access cycle that follows
  // completes combinationally so PREADY rises in the first PENABLE cycle.
  // Data reads go through StRdwait (wait state while the array read is in flight)
  // and complete in StAccess.
  assign fast_acc = (state_q == StSetup) && PSEL && PENABLE;
  assign read_acc = (state_q == StAccess);

  assign ctrl_wr = fast_acc && write_q && addr_ctrl;
  assign mem_we  = fast_acc && write_q && !addr_ctrl && !addr_oor && !busy_q;

  assign PREADY  = fast_acc || read_acc;
  assign PSLVERR = (fast_acc && write_q && (addr_oor || (!addr_ctrl && busy_q))) ||
                   (read_acc && addr_oor);

  assign start_work = start_q;

  always_comb begin
    ctrl_word                     = '0;
    ctrl_word[StartBit]           = start_q;
    ctrl_word[BusyBit]            = busy_q;
    ctrl_word[ResultLsb +: 2]     = result_q;
  end

  // PRDATA holds its last presented value outside access cycles.
  always_comb begin
    PRDATA = prdata_q;
    if (fast_acc && !write_q) begin
      PRDATA = ctrl_word;
    end else if (read_acc) begin
      PRDATA = addr_oor ? '0 : mem_rdata_a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StAccess: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            state_q <= (PWRITE || (PADDR == AW'(CtrlAddr))) ? StSetup : StRdwait;
          end else begin
            state_q <= StIdle;
          end
        end
        StSetup: begin
          if (!PSEL || PENABLE) begin
            state_q <= StIdle;
          end
        end
        StRdwait: begin
          if (!PSEL) begin
            state_q <= StIdle;
          end else if (PENABLE) begin
            state_q <= StAccess;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A CTRL write on the same edge as core_done wins for start/busy; result still updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= 2'b00;
      prdata_q <= '0;
    end else begin
      prdata_q <= PRDATA;
      if (core_done) begin
        start_q  <= 1'b0;
        busy_q   <= 1'b0;
        result_q <= core_result;
      end
      if (ctrl_wr) begin
        start_q <= wdata_q[StartBit];
        busy_q  <= wdata_q[StartBit];
      end
    end
  end

  regfile_mem #(
    .Width (AMBA_WORD),
    .AddrW (AW),
    .Depth (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_a    (mem_we),
    .addr_a  (addr_q),
    .wdata_a (wdata_q),
    .rdata_a (mem_rdata_a),
    .addr_b  (core_rd_addr),
    .rdata_b (core_rd_data)
  );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave with a behavioural register-file model.
module tb_apb_regfile_slave;

  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 4097;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          start_work;
  logic [AW-1:0] core_rd_addr = '0;
  logic [DW-1:0] core_rd_data;
  logic          core_done = 1'b0;
  logic [1:0]    core_result = 2'b00;

  always #5 clk = ~clk;

  apb_regfile_slave #(
    .AMBA_WORD       (24),
    .AMBA_ADDR_DEPTH (12),
    .DEPTH           (4097)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .start_work   (start_work),
    .core_rd_addr (core_rd_addr),
    .core_rd_data (core_rd_data),
    .core_done    (core_done),
    .core_result  (core_result)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: register file contents plus CTRL fields.
  logic [DW-1:0] mem_m [8192];
  bit            written_m [8192];
  logic          start_m = 1'b0;
  logic          busy_m = 1'b0;
  logic [1:0]    result_m = 2'b00;
  logic [DW-1:0] exp_core = '0;
  bit            exp_core_known = 1'b1;
  bit            in_xfer = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_range(input int a);
    return (a >= 1) && (a < int'(DEPTH));
  endfunction

  function automatic logic [DW-1:0] ctrl_m();
    return {20'b0, result_m, busy_m, start_m};
  endfunction

  task automatic model_reset();
    start_m  = 1'b0;
    busy_m   = 1'b0;
    result_m = 2'b00;
  endtask

  // Expected core read data: the word stored at the address seen on the edge.
  always @(posedge clk or negedge rst) begin : core_model
    int a;
    if (!rst) begin
      exp_core       = '0;
      exp_core_known = 1'b1;
    end else begin
      a = int'(core_rd_addr);
      if (in_range(a)) begin
        exp_core       = mem_m[a];
        exp_core_known = written_m[a];
      end else begin
        exp_core       = '0;
        exp_core_known = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("start_work", start_work, start_m);
      if (exp_core_known) chk("core_rd_data", core_rd_data, exp_core);
      if (!in_xfer) begin
        chk("pready_idle", PREADY, 1'b0);
        chk("pslverr_idle", PSLVERR, 1'b0);
      end
    end
  end

  task automatic apb_write(input int addr, input logic [DW-1:0] data, input bit hold,
                           input bit done_col);
    int waits;
    bit exp_err;
    exp_err = (addr >= int'(DEPTH)) || ((addr != 0) && busy_m);
    in_xfer = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(addr); PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    if (done_col) begin
      core_done = 1'b1; core_result = 2'd2;
    end
    waits = 0;
    forever begin
      @(negedge clk);
      if (PREADY === 1'b1 || waits >= 4) break;
      waits++;
      @(posedge clk); #1;
    end
    chk("wr_waits", waits, 0);
    chk("wr_pslverr", PSLVERR, exp_err);
    @(posedge clk); #1;
    if (done_col) begin
      core_done = 1'b0;
      start_m = 1'b0; busy_m = 1'b0; result_m = 2'd2;
    end
    if (addr == 0) begin
      start_m = data[0]; busy_m = data[0];
    end else if (!exp_err) begin
      mem_m[addr] = data; written_m[addr] = 1'b1;
    end
    PENABLE = 1'b0; PSEL = hold; in_xfer = hold;
  endtask

  task automatic apb_read(input int addr, output logic [DW-1:0] data);
    int waits;
    int exp_waits;
    bit exp_err;
    bit known;
    logic [DW-1:0] exp_data;
    exp_waits = (addr == 0) ? 0 : 1;
    exp_err   = addr >= int'(DEPTH);
    known     = (addr == 0) || exp_err || written_m[addr];
    exp_data  = (addr == 0) ? ctrl_m() : (exp_err ? '0 : mem_m[addr]);
    in_xfer = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = AW'(addr);
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (PREADY === 1'b1 || waits >= 4) break;
      waits++;
      @(posedge clk); #1;
    end
    data = PRDATA;
    chk("rd_waits", waits, exp_waits);
    chk("rd_pslverr", PSLVERR, exp_err);
    if (known) chk("rd_data", data, exp_data);
    @(posedge clk); #1;
    PENABLE = 1'b0; PSEL = 1'b0; in_xfer = 1'b0;
    @(negedge clk);
    if (known) chk("prdata_hold", PRDATA, exp_data);
  endtask

  task automatic pulse_done(input logic [1:0] r);
    core_done = 1'b1; core_result = r;
    @(posedge clk); #1;
    core_done = 1'b0;
    start_m = 1'b0; busy_m = 1'b0; result_m = r;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    logic [DW-1:0] d;
    logic [DW-1:0] wd;
    int sweep [6];
    sweep = '{0, 1, 2, 4095, 4097, 8191};

    // 1. Reset, first write and data read
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_start", start_work, 0);
    chk("rst_core", core_rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    apb_write(5, 24'hA1B2C3, 1'b0, 1'b0);
    apb_read(5, d);
    chk("t1_read5", d, 24'hA1B2C3);
    apb_write(7, 24'h123456, 1'b0, 1'b0);
    apb_read(0, d);
    chk("t1_ctrl_idle", d, 24'h000000);

    // 2. Start the core, data write while busy is rejected
    apb_write(0, 24'h000001, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_start", start_work, 1);
    apb_read(0, d);
    chk("t2_ctrl", d, 24'h000003);
    apb_write(7, 24'hFFFFFF, 1'b0, 1'b0);
    apb_read(7, d);
    chk("t2_read7_old", d, 24'h123456);

    // 3. Core completion, then completion colliding with a CTRL write, then abort
    pulse_done(2'd1);
    @(negedge clk);
    chk("t3_start", start_work, 0);
    apb_read(0, d);
    chk("t3_ctrl", d, 24'h000004);
    apb_write(0, 24'h000001, 1'b0, 1'b1);
    apb_read(0, d);
    chk("t3_collide", d, 24'h00000B);
    apb_write(0, 24'h000000, 1'b0, 1'b0);
    apb_read(0, d);
    chk("t3_abort", d, 24'h000008);

    // 4. Fill the whole array back-to-back, then read the last word via the core port
    for (int a = 1; a <= 4096; a++) begin
      wd = DW'(a) | 24'hC00000;
      apb_write(a, wd, a < 4096, 1'b0);
    end
    core_rd_addr = AW'(4096);
    @(posedge clk);
    @(negedge clk);
    chk("t4_core_last", core_rd_data, 24'hC01000);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      core_rd_addr = AW'(sweep[i]);
    end
    @(posedge clk); #1;
    core_rd_addr = '0;
    apb_read(4096, d);

    // 5. Out-of-range accesses and an aborted transfer
    apb_write(4097, 24'h0BAD00, 1'b0, 1'b0);
    apb_read(4097, d);
    chk("t5_oor_rd", d, 24'h000000);
    apb_read(1, d);
    chk("t5_alias1", d, 24'hC00001);
    in_xfer = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(3); PWDATA = 24'h333333;
    @(posedge clk); #1;
    PSEL = 1'b0;
    @(negedge clk);
    chk("t5_abort_pready", PREADY, 0);
    @(posedge clk); #1;
    in_xfer = 1'b0;
    apb_read(3, d);
    chk("t5_abort_mem", d, 24'hC00003);

    // 6b. Reset clears CTRL while the core is running
    apb_write(0, 24'h000001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t6_rst_start", start_work, 0);
    chk("t6_rst_prdata", PRDATA, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    apb_read(0, d);
    chk("t6_ctrl_after_rst", d, 24'h000000);

    // 6a. Reset in the middle of a data write
    in_xfer = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(9); PWDATA = 24'h999999;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    PSEL = 1'b0; PENABLE = 1'b0; in_xfer = 1'b0;
    @(negedge clk);
    chk("t6_midrst_pready", PREADY, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    apb_read(9, d);
    chk("t6_word9", d, 24'hC00009);
    chk("t6_start", start_work, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
